// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: each channel is independently OFF, ON, BLINK or
// retriggerable STRETCH, configured through a single-cycle write port.
module led_pattern_gen #(
    parameter int              N_CH       = 4,
    parameter int              CNT_W      = 32,
    parameter longint unsigned DEF_PERIOD = 1_000_000_000,
    parameter longint unsigned DEF_ON     = 500_000_000
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         cfg_we,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]   cfg_ch,
    input  logic [1:0]                                   cfg_mode,
    input  logic [CNT_W-1:0]                             cfg_period,
    input  logic [CNT_W-1:0]                             cfg_on,
    input  logic                                         sync,
    input  logic [N_CH-1:0]                              trig_in,
    output logic [N_CH-1:0]                              led_out
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] DEF_PERIOD_C = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] DEF_ON_C     = CNT_W'(DEF_ON);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_STRETCH = 2'd3
    } mode_t;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            localparam logic [CH_W-1:0] CH_IDX = CH_W'(gi);

            mode_t            mode_reg, mode_next;
            logic [CNT_W-1:0] period_reg, period_next;
            logic [CNT_W-1:0] on_reg, on_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic             active_reg, active_next;
            logic             led_reg, led_next;
            logic             trig_q_reg;
            logic             rise;
            logic             cfg_hit;

            assign rise    = trig_in[gi] & ~trig_q_reg;
            assign cfg_hit = cfg_we && (cfg_ch == CH_IDX);

            always_comb begin
                mode_next   = mode_reg;
                period_next = period_reg;
                on_next     = on_reg;
                cnt_next    = cnt_reg;
                active_next = active_reg;
                led_next    = 1'b0;

                case (mode_reg)
                    MODE_OFF: begin
                        led_next    = 1'b0;
                        cnt_next    = '0;
                        active_next = 1'b0;
                    end
                    MODE_ON: begin
                        led_next    = 1'b1;
                        cnt_next    = '0;
                        active_next = 1'b0;
                    end
                    MODE_BLINK: begin
                        led_next    = (cnt_reg < on_reg);
                        cnt_next    = (cnt_reg == period_reg) ? '0 : cnt_reg + CNT_W'(1);
                        active_next = 1'b0;
                    end
                    MODE_STRETCH: begin
                        // cnt counts elapsed high cycles and parks at on once the pulse ends
                        if (rise && (on_reg != '0)) begin
                            led_next    = 1'b1;
                            cnt_next    = CNT_W'(1);
                            active_next = 1'b1;
                        end else if (active_reg && (cnt_reg < on_reg)) begin
                            led_next    = 1'b1;
                            cnt_next    = cnt_reg + CNT_W'(1);
                        end else begin
                            led_next    = 1'b0;
                            active_next = 1'b0;
                        end
                    end
                    default: begin
                        led_next = 1'b0;
                    end
                endcase

                if (sync) begin
                    cnt_next    = '0;
                    active_next = 1'b0;
                end

                if (cfg_hit) begin
                    mode_next   = mode_t'(cfg_mode);
                    period_next = cfg_period;
                    on_next     = cfg_on;
                    cnt_next    = '0;
                    active_next = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    mode_reg   <= MODE_BLINK;
                    period_reg <= DEF_PERIOD_C;
                    on_reg     <= DEF_ON_C;
                    cnt_reg    <= '0;
                    active_reg <= 1'b0;
                    led_reg    <= 1'b0;
                    trig_q_reg <= 1'b0;
                end else begin
                    mode_reg   <= mode_next;
                    period_reg <= period_next;
                    on_reg     <= on_next;
                    cnt_reg    <= cnt_next;
                    active_reg <= active_next;
                    led_reg    <= led_next;
                    trig_q_reg <= trig_in[gi];
                end
            end

            assign led_out[gi] = led_reg;
        end
    endgenerate

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: the driver queues the expected LED
// vector for every clock edge, a separate monitor pops and compares it.
module tb_led_pattern_gen;

    localparam int N     = 5;
    localparam int CNT_W = 16;

    localparam logic [1:0] M_OFF     = 2'd0;
    localparam logic [1:0] M_ON      = 2'd1;
    localparam logic [1:0] M_BLINK   = 2'd2;
    localparam logic [1:0] M_STRETCH = 2'd3;

    logic             clk;
    logic             reset;
    logic             cfg_we;
    logic [2:0]       cfg_ch;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_on;
    logic             sync;
    logic [N-1:0]     trig_in;
    logic [N-1:0]     led_out;

    led_pattern_gen #(
        .N_CH       (N),
        .CNT_W      (CNT_W),
        .DEF_PERIOD (5),
        .DEF_ON     (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_on     (cfg_on),
        .sync       (sync),
        .trig_in    (trig_in),
        .led_out    (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] mask_q[$];
    logic [N-1:0] exp_q[$];
    string        tag_q[$];
    int           checks = 0;
    int           passes = 0;

    // One entry per clock edge; a zero mask marks an edge left unchecked.
    task automatic cyc(input logic [N-1:0] m, input logic [N-1:0] e, input string t);
        @(posedge clk);
        mask_q.push_back(m);
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] ch, input logic [1:0] mode,
                      input logic [CNT_W-1:0] per, input logic [CNT_W-1:0] on,
                      input logic [N-1:0] m, input logic [N-1:0] e, input string t);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_mode   = mode;
        cfg_period = per;
        cfg_on     = on;
        cyc(m, e, t);
        cfg_we     = 1'b0;
    endtask

    initial begin : monitor
        logic [N-1:0] m;
        logic [N-1:0] e;
        string        t;
        forever begin
            @(posedge clk);
            #1;
            if (mask_q.size() > 0) begin
                m = mask_q.pop_front();
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if (m != '0) begin
                    checks++;
                    if (((led_out ^ e) & m) == '0)
                        passes++;
                    else
                        $display("FAIL %s: led_out=%b required=%b (mask %b) at %0t",
                                 t, led_out & m, e & m, m, $time);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: stimulus did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [N-1:0] e;
        reset      = 1'b1;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_mode   = '0;
        cfg_period = '0;
        cfg_on     = '0;
        sync       = 1'b0;
        trig_in    = '0;

        repeat (3) cyc(5'h1f, 5'h00, "reset_state");
        reset = 1'b0;
        // Default BLINK: period 5 -> 6-cycle frame, 2 high then 4 low
        for (int i = 0; i < 12; i++)
            cyc(5'h1f, ((i % 6) < 2) ? 5'h1f : 5'h00, "default_blink");

        // ch0 BLINK period 9 on 5
        wr(3'd0, M_BLINK, 16'd9, 16'd5, 5'h00, 5'h00, "");
        for (int i = 0; i < 20; i++)
            cyc(5'h01, ((i % 10) < 5) ? 5'h01 : 5'h00, "blink_p9_on5");

        // ch1 BLINK boundaries
        wr(3'd1, M_BLINK, 16'd9, 16'd0, 5'h00, 5'h00, "");
        for (int i = 0; i < 12; i++) cyc(5'h02, 5'h00, "blink_on0");
        wr(3'd1, M_BLINK, 16'd9, 16'd12, 5'h00, 5'h00, "");
        for (int i = 0; i < 12; i++) cyc(5'h02, 5'h02, "blink_on_gt_period");
        wr(3'd1, M_BLINK, 16'd0, 16'd1, 5'h00, 5'h00, "");
        for (int i = 0; i < 8; i++) cyc(5'h02, 5'h02, "blink_period0");

        // ch2 STRETCH on 4
        wr(3'd2, M_STRETCH, 16'd0, 16'd4, 5'h00, 5'h00, "");
        repeat (3) cyc(5'h04, 5'h00, "stretch_idle");
        trig_in[2] = 1'b1;
        cyc(5'h04, 5'h04, "stretch_single");
        trig_in[2] = 1'b0;
        repeat (3) cyc(5'h04, 5'h04, "stretch_single");
        repeat (4) cyc(5'h04, 5'h00, "stretch_single_end");

        trig_in[2] = 1'b1;
        cyc(5'h04, 5'h04, "stretch_retrig");
        trig_in[2] = 1'b0;
        cyc(5'h04, 5'h04, "stretch_retrig");
        trig_in[2] = 1'b1;
        cyc(5'h04, 5'h04, "stretch_retrig");
        trig_in[2] = 1'b0;
        repeat (3) cyc(5'h04, 5'h04, "stretch_retrig");
        repeat (4) cyc(5'h04, 5'h00, "stretch_retrig_end");

        trig_in[2] = 1'b1;
        for (int i = 0; i < 20; i++)
            cyc(5'h04, (i < 4) ? 5'h04 : 5'h00, "stretch_held");
        trig_in[2] = 1'b0;
        repeat (3) cyc(5'h04, 5'h00, "stretch_held_end");

        wr(3'd2, M_STRETCH, 16'd0, 16'd0, 5'h00, 5'h00, "");
        trig_in[2] = 1'b1;
        repeat (2) cyc(5'h04, 5'h00, "stretch_on0");
        trig_in[2] = 1'b0;
        repeat (3) cyc(5'h04, 5'h00, "stretch_on0");

        // Phase alignment of ch0 and ch3 (period 7 on 3), written 4 edges apart
        wr(3'd0, M_BLINK, 16'd7, 16'd3, 5'h00, 5'h00, "");
        repeat (3) cyc(5'h00, 5'h00, "");
        wr(3'd3, M_BLINK, 16'd7, 16'd3, 5'h00, 5'h00, "");
        repeat (2) cyc(5'h00, 5'h00, "");
        sync = 1'b1;
        cyc(5'h00, 5'h00, "");
        sync = 1'b0;
        for (int i = 0; i < 16; i++)
            cyc(5'h09, ((i % 8) < 3) ? 5'h09 : 5'h00, "sync_align");

        // sync together with a write to ch3 (on 5); ch0 is 3 counts in at that edge
        wr(3'd0, M_BLINK, 16'd7, 16'd3, 5'h00, 5'h00, "");
        repeat (2) cyc(5'h00, 5'h00, "");
        sync = 1'b1;
        wr(3'd3, M_BLINK, 16'd7, 16'd5, 5'h00, 5'h00, "");
        sync = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e    = '0;
            e[0] = ((i % 8) < 3);
            e[3] = ((i % 8) < 5);
            cyc(5'h09, e, "sync_with_cfg");
        end

        // ON everywhere (ch1 is already constant high), then out-of-range writes
        wr(3'd0, M_ON, 16'd0, 16'd0, 5'h00, 5'h00, "");
        wr(3'd2, M_ON, 16'd0, 16'd0, 5'h00, 5'h00, "");
        wr(3'd3, M_ON, 16'd0, 16'd0, 5'h00, 5'h00, "");
        wr(3'd4, M_ON, 16'd0, 16'd0, 5'h00, 5'h00, "");
        repeat (4) cyc(5'h1f, 5'h1f, "on_mode");
        for (int c = 5; c < 8; c++) begin
            wr(3'(c), M_OFF, 16'd0, 16'd0, 5'h1f, 5'h1f, "oor_write");
            repeat (2) cyc(5'h1f, 5'h1f, "oor_hold");
        end
        wr(3'd0, M_OFF, 16'd0, 16'd0, 5'h00, 5'h00, "");
        wr(3'd4, M_OFF, 16'd0, 16'd0, 5'h00, 5'h00, "");
        repeat (6) cyc(5'h1f, 5'h0e, "off_mode");

        // Reset in the middle of a BLINK high phase and a STRETCH pulse
        wr(3'd0, M_BLINK, 16'd9, 16'd5, 5'h00, 5'h00, "");
        wr(3'd2, M_STRETCH, 16'd0, 16'd10, 5'h00, 5'h00, "");
        trig_in[2] = 1'b1;
        cyc(5'h05, 5'h05, "pre_reset_high");
        trig_in[2] = 1'b0;
        cyc(5'h05, 5'h05, "pre_reset_high");
        reset      = 1'b1;
        sync       = 1'b1;
        cfg_we     = 1'b1;
        cfg_ch     = 3'd1;
        cfg_mode   = M_ON;
        repeat (2) cyc(5'h1f, 5'h00, "reset_mid");
        reset  = 1'b0;
        sync   = 1'b0;
        cfg_we = 1'b0;
        for (int i = 0; i < 12; i++)
            cyc(5'h1f, ((i % 6) < 2) ? 5'h1f : 5'h00, "reset_resume");

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (mask_q.size() == 0)
            passes++;
        else
            $display("FAIL scoreboard_drain: pending=%0d required=0", mask_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
